// File: rtl/angle_sequencer_if.sv
// Control/status bundle between the angle sequencer and its host:
// run/step requests in, modulator angle/shoot and status pulses out.
interface angle_sequencer_if;
  logic        enable;
  logic [11:0] step_in;
  logic        step_load;
  logic [11:0] angle;
  logic        shoot;
  logic        wrap;
  logic        step_ack;

  modport master (
    output enable, step_in, step_load,
    input  angle, shoot, wrap, step_ack
  );

  modport slave (
    input  enable, step_in, step_load,
    output angle, shoot, wrap, step_ack
  );
endinterface

// File: rtl/angle_sequencer.sv
// Periodic fire-strobe generator that advances a 12-bit modulator angle by a
// programmable step once per period, holding it steady around each shoot pulse.
module angle_sequencer #(
  parameter int PERIOD     = 200,
  parameter int SHOOT_LEN  = 50,
  parameter int STEP_RESET = 10
) (
  input  logic               clk,
  input  logic               reset,
  angle_sequencer_if.slave   bus
);

  localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] SHOOT_END = CNT_W'(SHOOT_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHOOT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [11:0]      angle_q;
  logic [11:0]      step_q;
  logic             first_q;
  logic             shoot_q;
  logic             wrap_q;
  logic             step_ack_q;
  logic [12:0]      sum;

  // Bit 12 is the carry out of the 12-bit angle accumulator.
  assign sum = {1'b0, angle_q} + {1'b0, step_q};

  // NOTE: reset is synchronous and active-low; every register, including the
  // step and first-SETUP flag, is explicitly returned to a known value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      angle_q    <= '0;
      step_q     <= 12'(STEP_RESET);
      first_q    <= 1'b1;
      shoot_q    <= 1'b0;
      wrap_q     <= 1'b0;
      step_ack_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here so every register sees
      // the pre-edge value of its peers, e.g. SETUP uses the old step_q even
      // when step_load lands on the same edge.
      step_ack_q <= bus.step_load;
      if (bus.step_load) begin
        step_q <= bus.step_in;
      end

      wrap_q <= 1'b0;
      // shoot trails the SHOOT state by one cycle, giving the angle a full
      // cycle to settle before the modulator fires.
      shoot_q <= (state_q == SHOOT);

      case (state_q)
        IDLE: begin
          if (bus.enable) begin
            state_q <= SETUP;
            cnt_q   <= '0;
          end
        end

        SETUP: begin
          if (!first_q) begin
            angle_q <= sum[11:0];
            wrap_q  <= sum[12];
          end
          first_q <= 1'b0;
          state_q <= SHOOT;
          cnt_q   <= CNT_ONE;
        end

        SHOOT: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == SHOOT_END) begin
            state_q <= GAP;
          end
        end

        GAP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= bus.enable ? SETUP : IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.angle    = angle_q;
  assign bus.shoot    = shoot_q;
  assign bus.wrap     = wrap_q;
  assign bus.step_ack = step_ack_q;

endmodule

// File: doc/angle_sequencer.md
ANGLE_SEQUENCER -- requirements
Module: angle_sequencer

Interface
REQ-001 SHALL have parameter PERIOD, default 200: clock cycles between consecutive shoot rising edges.
REQ-002 SHALL have parameter SHOOT_LEN, default 50: cycles shoot stays high per period.
REQ-003 SHALL have parameter STEP_RESET, default 10: angle increment loaded at reset.
REQ-004 SHALL have port: clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port: enable  input  1  run request, level-sensitive.
REQ-007 SHALL have port: step_in  input  12  new angle increment.
REQ-008 SHALL have port: step_load  input  1  one-cycle strobe capturing step_in.
REQ-009 SHALL have port: angle  output  12  registered angle for the modulator angle input.
REQ-010 SHALL have port: shoot  output  1  registered fire strobe for the modulator shoot input.
REQ-011 SHALL have port: wrap  output  1  one-cycle pulse when the angle addition overflows 12 bits.
REQ-012 SHALL have port: step_ack  output  1  one-cycle pulse acknowledging step_load.

Function
REQ-013 SHALL implement states IDLE, SETUP, SHOOT, GAP, driven by a period counter cnt spanning 0..PERIOD-1.
REQ-014 IDLE: shoot=0, angle held; enable=1 sampled -> SETUP (cnt=0) next cycle.
REQ-015 SETUP (one cycle): angle <= angle+step mod 4096, except the first SETUP after reset, which leaves angle unchanged; -> SHOOT.
REQ-016 SHOOT: shoot=1 for exactly SHOOT_LEN cycles (cnt 1..SHOOT_LEN); -> GAP.
REQ-017 GAP: shoot=0 until cnt=PERIOD-1; then -> SETUP if enable=1, else IDLE.
REQ-018 angle SHALL be stable from one cycle before shoot rises until after shoot falls; it SHALL only change in SETUP.
REQ-019 Shoot rising edges SHALL be spaced exactly PERIOD cycles while enable stays 1; first rising edge SHALL occur 2 cycles after enable is sampled high in IDLE.
REQ-020 wrap SHALL pulse for one cycle, coincident with the updated angle, when angle+step >= 4096; otherwise 0.
REQ-021 step_load=1 SHALL capture step_in into the step register at that edge; step_ack=1 for the following cycle only; new step applies at the next SETUP, never mid-period.
REQ-022 step_load on consecutive cycles: last value wins; one step_ack per strobe.
REQ-023 step=0 is legal: angle constant, wrap never asserted.
REQ-024 enable deasserted mid-period: current period (shoot and gap) SHALL complete; then IDLE with angle held; re-enable SHALL increment at its SETUP.
REQ-025 Parameters SHALL satisfy 1 <= SHOOT_LEN <= PERIOD-2; cnt width SHALL be clog2(PERIOD).

Reset
REQ-026 reset=0 at an edge SHALL force IDLE, cnt=0, angle=0, shoot=0, wrap=0, step_ack=0, step=STEP_RESET, first-SETUP flag set, overriding any state including mid-SHOOT and a concurrent step_load.

Verification (PERIOD=20, SHOOT_LEN=5, STEP_RESET=10)
REQ-027 Reset: reset=0 for 3 cycles, then 1 with enable=0 -> angle=0, shoot=0, wrap=0 held for 50 cycles.
REQ-028 Run: enable=1 -> shoot high 5 cycles every 20 cycles, first rise 2 cycles after enable; angle per shoot 0,10,20,30.
REQ-029 Wrap: load step_in=0x7FF before enable -> angles 0x000, 0x7FF, 0xFFE, 0x7FD; wrap pulses once, with 0x7FD.
REQ-030 Mid-period load: step_load with step_in=100 during SHOOT -> step_ack next cycle; angle unchanged through that period; next angle = previous+100.
REQ-031 Enable drop in GAP -> period completes, no further shoot, angle held; re-enable -> next angle = held+step.
REQ-032 Reset during SHOOT (3rd cycle) -> next cycle shoot=0, angle=0; after re-run, first shoot uses angle 0.
